proc_sequencer: RTL
===================

# proc_sequencer

Boot and run sequencer for the pipelined processor core. It receives a program as a little-endian byte stream and writes it word-by-word into instruction memory, holding the core in reset meanwhile. It then releases the core, watches `pcf` for a halt address or a cycle limit, drains the pipeline and puts the core back in reset. It sits between the host link (UART/loader) and the core's `rst`/instruction-memory port.

## Interface
- `MAX_CYCLES`, 65535: run-cycle limit before timeout.
- `DRAIN_CYCLES`, 4: cycles the core keeps running after halt detection so in-flight writes retire.
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high
- `start`  in  1  single-cycle request to begin load+run
- `prog_len`  in  16  program length in words; latched on accepted `start`
- `halt_pc`  in  32  byte address of the final instruction; latched on accepted `start`
- `in_byte`  in  8  program byte
- `in_valid`  in  1  `in_byte` valid
- `in_ready`  out  1  sequencer accepts a byte this cycle
- `imem_we`  out  1  instruction-memory write strobe
- `imem_addr`  out  32  byte address, word aligned
- `imem_wdata`  out  32  assembled word
- `core_rst`  out  1  drives the core's `rst`
- `pcf`  in  32  core fetch PC
- `busy`  out  1  high in LOAD, RUN and DRAIN
- `done`  out  1  run finished; held until the next accepted `start`
- `timeout`  out  1  run ended by the cycle limit; valid while `done` is high
- `cycles`  out  32  cycles with `core_rst` low in the last or current run

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - `core_rst`=1.
  - `start` with `prog_len`≠0 → LOAD, clearing word and byte counters, `cycles`, `done` and `timeout`.
  - `start` with `prog_len`=0 is ignored.
- LOAD:
  - `in_ready`=1, `core_rst`=1.
  - A byte is accepted when `in_valid & in_ready`. Byte k of a word goes to bits [8k+7:8k], so the first byte is the LSB.
  - On the 4th accepted byte, the next cycle drives `imem_we`=1, `imem_addr`=4·word_cnt and `imem_wdata`=word, then word_cnt increments.
  - `in_ready` is low during that write cycle.
  - After the write of word `prog_len`−1 → RUN.
- RUN:
  - `core_rst`=0, `cycles` increments every cycle.
  - `pcf`==`halt_pc` → DRAIN. This includes the first RUN cycle, so `halt_pc`=0 halts immediately.
  - Else if `cycles`==`MAX_CYCLES`−1 → DONE with `timeout`=1.
  - Halt and limit in the same cycle: halt wins, `timeout`=0.
- DRAIN: `core_rst`=0, `cycles` increments. After `DRAIN_CYCLES` cycles → DONE. The limit is not checked.
- DONE:
  - `core_rst`=1, `done`=1.
  - `start` → LOAD under the same rules as IDLE.
- `start` in LOAD, RUN or DRAIN is ignored.
- Reset values: `core_rst`=1; `in_ready`, `imem_we`, `busy`, `done`, `timeout`=0; `imem_addr`, `imem_wdata`, `cycles`=0; state IDLE.
- Reset mid-operation aborts immediately. No partial word is written, and `core_rst` asserts asynchronously.

## Timing
- `start` sampled at edge N → `in_ready` high in cycle N+1.
- 4th byte accepted at edge k → `imem_we` high in cycle k+1, for exactly one cycle.
- Last write in cycle w → `core_rst` low from cycle w+1.
- Halt seen in RUN cycle h → `core_rst` low through h+`DRAIN_CYCLES`, with `done` and `core_rst` high in the next cycle.
- All outputs are registered except `in_ready`, which is decoded from the state register.
- Final `cycles` = RUN cycles + DRAIN cycles.

## Structure
- Package `proc_seq_pkg`: state enum `seq_state_t`, default `DRAIN_CYCLES`, word and byte-count widths.
- One sub-module `byte_packer`: byte counter plus shift register, emitting `word_valid`/`word` with a synchronous clear.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs at reset values immediately, `core_rst`=1.
- Load: `prog_len`=2, bytes 90 01 80 80 2C 01 00 81 →
  - writes addr 0x0 data 0x80800190;
  - writes addr 0x4 data 0x8100012C;
  - `core_rst` falls the cycle after the second write.
- Halt: `halt_pc`=0x14, core model PC advances +4 per cycle from 0 →
  - halt in the 6th RUN cycle;
  - `done`=1, `timeout`=0, `cycles`=10.
- Timeout: `MAX_CYCLES`=16, `halt_pc` never reached → `done`=1, `timeout`=1, `cycles`=16.
- Back-pressure and ignores: random `in_valid` gaps, plus `start` pulses during LOAD and RUN → identical memory contents, no restart.
- Reset mid-LOAD after 5 bytes, then a fresh load → first write at addr 0 with the new data, no stale bytes.

Source files
------------

// File: rtl/proc_seq_pkg.sv
// Shared types and widths for the boot/run sequencer.
package proc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  localparam int unsigned DRAIN_CYCLES_DEFAULT = 4;
  localparam int unsigned WORD_CNT_W           = 16;
  localparam int unsigned BYTE_CNT_W           = 2;
  localparam int unsigned DRAIN_CNT_W          = 8;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; first byte lands in the LSB.
module byte_packer
  import proc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [BYTE_CNT_W-1:0] byte_cnt;

  // Shift each byte in from the top so after four bytes byte 0 sits in [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clr) begin
      byte_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        word     <= {byte_in, word[31:8]};
        byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
        if (byte_cnt == '1) begin
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/proc_sequencer.sv
// Boot and run sequencer: loads a program into instruction memory while holding
// the core in reset, then runs it until a halt PC or cycle limit, drains, and stops.
module proc_sequencer
  import proc_seq_pkg::*;
#(
  parameter int unsigned MAX_CYCLES   = 65535,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] prog_len,
  input  logic [31:0] halt_pc,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  input  logic [31:0] pcf,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycles
);

  localparam logic [31:0]            MAX_M1   = 32'(MAX_CYCLES - 1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_M1 = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  seq_state_t             state;
  logic [WORD_CNT_W-1:0]  prog_len_q;
  logic [31:0]            halt_pc_q;
  logic [WORD_CNT_W-1:0]  word_cnt;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic                   start_ok;
  logic                   word_valid;
  logic [31:0]            word;

  // A start is only honoured from IDLE/DONE and with a non-empty program.
  assign start_ok = start && (prog_len != '0) && ((state == ST_IDLE) || (state == ST_DONE));

  // Bytes are refused during the write cycle so the packer never overruns a pending word.
  assign in_ready = (state == ST_LOAD) && !word_valid;

  byte_packer u_byte_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .byte_in    (in_byte),
    .byte_valid (in_valid && in_ready),
    .word_valid (word_valid),
    .word       (word)
  );

  assign imem_we    = word_valid;
  assign imem_wdata = word;
  assign imem_addr  = {{(32 - WORD_CNT_W - 2){1'b0}}, word_cnt, 2'b00};

  // Sequencer state, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      prog_len_q <= '0;
      halt_pc_q  <= '0;
      word_cnt   <= '0;
      drain_cnt  <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      cycles     <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state      <= ST_LOAD;
            prog_len_q <= prog_len;
            halt_pc_q  <= halt_pc;
            word_cnt   <= '0;
            cycles     <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            word_cnt <= word_cnt + WORD_CNT_W'(1);
            if (word_cnt == prog_len_q - WORD_CNT_W'(1)) begin
              state    <= ST_RUN;
              core_rst <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          cycles <= cycles + 32'd1;
          // Halt takes priority over the limit when both hit in the same cycle.
          if (pcf == halt_pc_q) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end else if (cycles == MAX_M1) begin
            state    <= ST_DONE;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            timeout  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          cycles    <= cycles + 32'd1;
          drain_cnt <= drain_cnt + DRAIN_CNT_W'(1);
          if (drain_cnt == DRAIN_M1) begin
            state    <= ST_DONE;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          core_rst <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
